// File: rtl/proj_fm_ring.sv
// proj_fm_ring: ring of BUFFER_COUNT symbol buffers. The write buffer fills
// while the newest completed buffer serves reads. Negative read indices reach
// back into the buffer completed before it.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_in_valid/o_in_ready   write symbol stream; i_in_wdata is the symbol
//   o_wr_full               write buffer complete, waiting for i_chg_idx
//                           (this is also the FILL/FULL state bit)
//   i_chg_idx / o_chg_err   rotate request / pulse when a request is ignored
//   o_rd_buf_valid          a completed buffer is mapped for reads
//   i_rd_valid, i_frag_idx  per-port read request and signed start index
//   o_out_valid, o_out_rdata, o_out_oob  per-port registered read results
//
// Handshake: a symbol transfers on a rising edge where i_in_valid and
// o_in_ready are both high. o_in_ready depends only on internal state, never
// on i_in_valid. A symbol offered while o_in_ready is low is not taken, and
// the source must keep holding it.
module proj_fm_ring #(
  parameter int BUFFER_COUNT      = 3,
  parameter int BUFFER_SIZE       = 64,
  parameter int DATA_BITS         = 2,
  parameter int FRAG_SYMS         = 8,
  parameter int READ_PORTS        = 2,
  parameter int SIGNED_INDICE_LEN = 8
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_in_valid,
  output logic                                        o_in_ready,
  input  logic [DATA_BITS-1:0]                        i_in_wdata,
  output logic                                        o_wr_full,
  input  logic                                        i_chg_idx,
  output logic                                        o_chg_err,
  output logic                                        o_rd_buf_valid,
  input  logic [READ_PORTS-1:0]                       i_rd_valid,
  input  logic [READ_PORTS*SIGNED_INDICE_LEN-1:0]     i_frag_idx,
  output logic [READ_PORTS-1:0]                       o_out_valid,
  output logic [READ_PORTS*FRAG_SYMS*DATA_BITS-1:0]   o_out_rdata,
  output logic [READ_PORTS-1:0]                       o_out_oob
);

  localparam int ADDR_W = $clog2(BUFFER_SIZE);
  localparam int BUF_W  = $clog2(BUFFER_COUNT);
  localparam int FRAG_W = FRAG_SYMS * DATA_BITS;
  // Two extra bits so idx + (FRAG_SYMS-1) cannot overflow.
  localparam int Q_W    = SIGNED_INDICE_LEN + 2;

  localparam logic signed [Q_W-1:0] Q_ZERO = '0;
  localparam logic signed [Q_W-1:0] Q_POS  = Q_W'(BUFFER_SIZE);
  localparam logic signed [Q_W-1:0] Q_NEG  = Q_W'(-BUFFER_SIZE);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]        r_state;
  logic [BUF_W-1:0]  r_wr_buf;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [BUF_W-1:0]  r_rd_buf;
  logic [BUF_W-1:0]  r_prev_buf;
  logic              r_rd_buf_valid;
  logic              r_prev_valid;
  logic              r_chg_err;
  logic [READ_PORTS-1:0]             r_out_valid;
  logic [READ_PORTS-1:0][FRAG_W-1:0] r_rdata;
  logic [READ_PORTS-1:0]             r_oob;

  logic [DATA_BITS-1:0] r_mem [BUFFER_COUNT][BUFFER_SIZE];

  logic                              w_wr_acc;
  logic                              w_rotate;
  logic [BUF_W-1:0]                  w_wr_buf_nxt;
  logic [READ_PORTS-1:0][FRAG_W-1:0] w_frag;
  logic [READ_PORTS-1:0]             w_oob;

  assign o_in_ready     = (r_state == ST_FILL);
  assign o_wr_full      = (r_state == ST_FULL);
  assign o_chg_err      = r_chg_err;
  assign o_rd_buf_valid = r_rd_buf_valid;
  assign o_out_valid    = r_out_valid;
  assign o_out_rdata    = r_rdata;
  assign o_out_oob      = r_oob;

  assign w_wr_acc     = i_in_valid && (r_state == ST_FILL);
  assign w_rotate     = i_chg_idx && (r_state == ST_FULL);
  // Advancing by one always lands on the oldest buffer, which the rotation frees.
  assign w_wr_buf_nxt = (r_wr_buf == BUF_W'(BUFFER_COUNT - 1)) ? '0 : r_wr_buf + BUF_W'(1);

  // Buffer contents carry no reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_buf][r_wr_addr] <= i_in_wdata;
    end
  end

  // Fragment gather. Because BUFFER_SIZE is a power of two, the low address
  // bits of q equal q + BUFFER_SIZE for negative q. One address therefore
  // serves both the current buffer and the previous buffer.
  always_comb begin
    logic signed [Q_W-1:0] q;
    logic [ADDR_W-1:0]     addr;
    w_frag = '0;
    w_oob  = '0;
    q      = '0;
    addr   = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      for (int j = 0; j < FRAG_SYMS; j++) begin
        q    = Q_W'($signed(i_frag_idx[p*SIGNED_INDICE_LEN +: SIGNED_INDICE_LEN])) + Q_W'(j);
        addr = q[ADDR_W-1:0];
        if (q >= Q_ZERO && q < Q_POS) begin
          if (r_rd_buf_valid) w_frag[p][j*DATA_BITS +: DATA_BITS] = r_mem[r_rd_buf][addr];
          else                w_oob[p] = 1'b1;
        end else if (q >= Q_NEG && q < Q_ZERO) begin
          if (r_prev_valid) w_frag[p][j*DATA_BITS +: DATA_BITS] = r_mem[r_prev_buf][addr];
          else              w_oob[p] = 1'b1;
        end else begin
          w_oob[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_FILL;
      r_wr_buf       <= '0;
      r_wr_addr      <= '0;
      r_rd_buf       <= '0;
      r_prev_buf     <= '0;
      r_rd_buf_valid <= 1'b0;
      r_prev_valid   <= 1'b0;
      r_chg_err      <= 1'b0;
      r_out_valid    <= '0;
      r_rdata        <= '0;
      r_oob          <= '0;
    end else begin
      r_chg_err <= i_chg_idx && (r_state == ST_FILL);
      if (w_wr_acc) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
        if (r_wr_addr == ADDR_W'(BUFFER_SIZE - 1)) r_state <= ST_FULL;
      end
      if (w_rotate) begin
        r_rd_buf       <= r_wr_buf;
        r_prev_buf     <= r_rd_buf;
        r_prev_valid   <= r_rd_buf_valid;
        r_rd_buf_valid <= 1'b1;
        r_wr_buf       <= w_wr_buf_nxt;
        r_state        <= ST_FILL;
      end
      // The read in a rotating cycle used the old mapping via w_frag.
      r_out_valid <= i_rd_valid;
      for (int p = 0; p < READ_PORTS; p++) begin
        if (i_rd_valid[p]) begin
          r_rdata[p] <= w_frag[p];
          r_oob[p]   <= w_oob[p];
        end
      end
    end
  end

endmodule

// File: doc/proj_fm_ring.md
Name: proj_fm_ring

Overview:
- Fragment memory for the minhash front end, generalising the two-buffer ping-pong fragment memory.
- Holds a ring of BUFFER_COUNT symbol buffers. A write-side valid/ready stream fills one buffer while another buffer serves reads.
- Serves READ_PORTS independent fragment reads per cycle with signed indices. Negative indices reach back into the previously completed buffer.
- Sits between the input symbol stream and the k-mer/hash extenders.

Parameters:
- BUFFER_COUNT, 3: buffers in the ring; minimum 3 (write, current read, previous).
- BUFFER_SIZE, 64: symbols per buffer; power of two.
- DATA_BITS, 2: bits per symbol.
- FRAG_SYMS, 8: symbols per returned fragment.
- READ_PORTS, 2: independent read channels.
- SIGNED_INDICE_LEN, 8: width of the two's-complement frag_idx; must cover -BUFFER_SIZE..BUFFER_SIZE-1.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_wdata carries a symbol.
- in_ready, output, 1: block accepts a symbol this cycle.
- in_wdata, input, DATA_BITS: write symbol.
- wr_full, output, 1: write buffer complete, awaiting chg_idx.
- chg_idx, input, 1: single-cycle request to rotate buffers.
- chg_err, output, 1: one-cycle pulse when chg_idx is ignored.
- rd_buf_valid, output, 1: a completed buffer is available for reads.
- rd_valid, input, READ_PORTS: per-port read request.
- frag_idx, input, READ_PORTS*SIGNED_INDICE_LEN: per-port signed start index; port p occupies slice p.
- out_valid, output, READ_PORTS: per-port read result valid.
- out_rdata, output, READ_PORTS*FRAG_SYMS*DATA_BITS: per-port fragment.
- out_oob, output, READ_PORTS: per-port flag; fragment touched unavailable positions.

Behaviour:
- Reset (async, rst_n low):
  - wr_buf=0, wr_addr=0, wr_full=0, rd_buf_valid=0, prev_valid=0.
  - out_valid=0, out_rdata=0, out_oob=0, chg_err=0.
  - in_ready=1, since it is combinational: in_ready = !wr_full.
  - Buffer contents are not reset.
- Write path:
  - On in_valid&&in_ready, store in_wdata at buffer wr_buf, address wr_addr; wr_addr increments.
  - When the symbol at BUFFER_SIZE-1 is accepted, wr_addr wraps to 0 and wr_full=1 from the next cycle.
  - in_valid while in_ready=0 is dropped; upstream must hold it.
- States: FILL (wr_full=0) and FULL (wr_full=1).
  - FULL + chg_idx:
    - rd_buf<=wr_buf, prev_buf<=old rd_buf, prev_valid<=rd_buf_valid, rd_buf_valid<=1.
    - wr_buf<=(wr_buf+1) mod BUFFER_COUNT, skipping no slot, because the oldest buffer is freed.
    - wr_full<=0. Writes resume the next cycle.
  - FILL + chg_idx: ignored; chg_err=1 for one cycle. A write in the same cycle proceeds normally.
- Read path, per port, independent:
  - Symbol positions are q = idx+j, for j = 0..FRAG_SYMS-1.
  - 0<=q<BUFFER_SIZE: rd_buf[q], or 0 if !rd_buf_valid.
  - -BUFFER_SIZE<=q<0: prev_buf[q+BUFFER_SIZE] if prev_valid, else 0.
  - q>=BUFFER_SIZE or q<-BUFFER_SIZE: 0.
  - Any zero-substituted position sets out_oob for that result.
  - Symbol j is placed at out_rdata bits [j*DATA_BITS +: DATA_BITS] within the port slice; symbol at idx is in the LSBs.
- Read latency: 1 cycle.
  - out_valid[p] is rd_valid[p] registered.
  - out_rdata and out_oob update only when rd_valid[p]=1, otherwise hold.
- A read in the same cycle as an accepted chg_idx uses the pre-rotation mapping.
- Ports reading the same address return identical data; there is no port conflict.
- A write and a read never target the same buffer, because wr_buf ≠ rd_buf and wr_buf ≠ prev_buf by construction.

Test Plan:
1. Reset, then write 64 symbols with value i%4 → in_ready=0 and wr_full=1 the cycle after the 64th accept; a 65th in_valid is not accepted.
2. chg_idx → rd_buf_valid=1. Port0 frag_idx=0 → next cycle out_valid[0]=1, out_rdata port0=16'hE4E4, out_oob=0. Port1 frag_idx=-2 in the same cycle → 16'h4E40, out_oob[1]=1 (prev invalid).
3. Fill the next buffer with constant 2, then chg_idx. frag_idx=-2 → 16'hAAAE, out_oob=0 (prev buffer reached). frag_idx=-64 → 16'hE4E4.
4. frag_idx=60 → 16'h00AA, out_oob=1. Simultaneously on port1, frag_idx=-65 → out_oob=1 with the low symbol zero.
5. chg_idx after 10 writes → chg_err pulses for 1 cycle; the mapping is unchanged (port0 frag_idx=0 still 16'hAAAA); wr_addr continues at 10.
6. Assert rst_n low asynchronously mid-clock after 30 writes → outputs immediately reach reset values; reads after release return 0 with out_oob=1; the next fill starts at buffer 0, address 0.
